// File: rtl/mem_check_sequencer.sv
// mem_check_sequencer: on-chip debug-port checker for the CPU toplevel.
// Holds the DUT in reset, lets it run for a fixed window, issues the
// debug-entry command bytes, then walks an (address, expected value) table
// comparing each debug readback and accumulating pass/fail results.
module mem_check_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int N_CHECKS   = 64,
    parameter int CNT_W      = $clog2(N_CHECKS + 1),
    parameter int RUN_CYCLES = 400,
    parameter int READ_LAT   = 1,
    parameter logic [ADDR_W-1:0] ARM0 = ADDR_W'(8'h14),
    parameter logic [ADDR_W-1:0] ARM1 = ADDR_W'(8'h01)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_fail,
    input  logic [CNT_W-1:0]  num_checks,
    output logic [CNT_W-1:0]  vec_idx,
    input  logic [ADDR_W-1:0] vec_addr,
    input  logic [DATA_W-1:0] vec_exp,
    output logic              dut_hold,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_got
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_ARM0  = 3'd2;
    localparam logic [2:0] S_ARM1  = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_CMP   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int RUN_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LAT > 0) ? (READ_LAT - 1) : 0);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(N_CHECKS);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Requested vector counts above the table size run the whole table.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
        if (req > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return req;
        end
    endfunction

    logic [2:0]        state_r,    state_n;
    logic [RUN_W-1:0]  run_cnt_r,  run_cnt_n;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_n;
    logic [CNT_W-1:0]  num_r,      num_n;
    logic              stop_r,     stop_n;
    logic [CNT_W-1:0]  vec_idx_r,  vec_idx_n;
    logic [ADDR_W-1:0] dbg_addr_r, dbg_addr_n;
    logic              dut_hold_r, dut_hold_n;
    logic              busy_r,     busy_n;
    logic              done_r,     done_n;
    logic              pass_r,     pass_n;
    logic [CNT_W-1:0]  pass_cnt_r, pass_cnt_n;
    logic [CNT_W-1:0]  fail_cnt_r, fail_cnt_n;
    logic [CNT_W-1:0]  ff_idx_r,   ff_idx_n;
    logic [DATA_W-1:0] ff_got_r,   ff_got_n;

    logic match_s;
    logic last_s;
    logic active_s;
    logic launch_s;

    assign match_s  = (dbg_data == vec_exp);
    assign last_s   = (vec_idx_r == (num_r - CNT_ONE));
    assign active_s = (state_r != S_IDLE) && (state_r != S_DONE);
    assign launch_s = start && !active_s;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_n    = state_r;
        run_cnt_n  = run_cnt_r;
        wait_cnt_n = wait_cnt_r;
        num_n      = num_r;
        stop_n     = stop_r;
        vec_idx_n  = vec_idx_r;
        dbg_addr_n = dbg_addr_r;
        dut_hold_n = dut_hold_r;
        busy_n     = busy_r;
        done_n     = done_r;
        pass_n     = pass_r;
        pass_cnt_n = pass_cnt_r;
        fail_cnt_n = fail_cnt_r;
        ff_idx_n   = ff_idx_r;
        ff_got_n   = ff_got_r;

        if (abort && active_s) begin
            // Cancel wins over everything; results are left frozen for inspection.
            state_n    = S_IDLE;
            dut_hold_n = 1'b1;
            busy_n     = 1'b0;
            done_n     = 1'b0;
            pass_n     = 1'b0;
        end else if (launch_s) begin
            state_n    = S_RUN;
            stop_n     = stop_on_fail;
            num_n      = clamp_count(num_checks);
            run_cnt_n  = {RUN_W{1'b0}};
            vec_idx_n  = CNT_ZERO;
            pass_cnt_n = CNT_ZERO;
            fail_cnt_n = CNT_ZERO;
            ff_idx_n   = {CNT_W{1'b1}};
            ff_got_n   = {DATA_W{1'b0}};
            dut_hold_n = 1'b0;
            busy_n     = 1'b1;
            done_n     = 1'b0;
            pass_n     = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    dut_hold_n = 1'b1;
                    busy_n     = 1'b0;
                end
                S_RUN: begin
                    if (run_cnt_r == RUN_LAST) begin
                        state_n    = S_ARM0;
                        dbg_addr_n = ARM0;
                    end else begin
                        run_cnt_n = run_cnt_r + RUN_W'(1);
                    end
                end
                S_ARM0: begin
                    state_n    = S_ARM1;
                    dbg_addr_n = ARM1;
                end
                S_ARM1: begin
                    if (num_r == CNT_ZERO) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dbg_addr_n = vec_addr;
                    wait_cnt_n = {WAIT_W{1'b0}};
                    if (READ_LAT > 0) begin
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_CMP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_n = S_CMP;
                    end else begin
                        wait_cnt_n = wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_CMP: begin
                    if (match_s) begin
                        pass_cnt_n = pass_cnt_r + CNT_ONE;
                    end else begin
                        fail_cnt_n = fail_cnt_r + CNT_ONE;
                        if (fail_cnt_r == CNT_ZERO) begin
                            ff_idx_n = vec_idx_r;
                            ff_got_n = dbg_data;
                        end else begin
                            ff_idx_n = ff_idx_r;
                        end
                    end
                    if (last_s || (!match_s && stop_r)) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (fail_cnt_n == CNT_ZERO);
                    end else begin
                        state_n   = S_ISSUE;
                        vec_idx_n = vec_idx_r + CNT_ONE;
                    end
                end
                S_DONE: begin
                    // DUT keeps running after the check so it can be observed.
                    dut_hold_n = 1'b0;
                    done_n     = 1'b1;
                end
                default: begin
                    state_n    = S_IDLE;
                    dut_hold_n = 1'b1;
                    busy_n     = 1'b0;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            run_cnt_r  <= {RUN_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            num_r      <= CNT_ZERO;
            stop_r     <= 1'b0;
            vec_idx_r  <= CNT_ZERO;
            dbg_addr_r <= {ADDR_W{1'b0}};
            dut_hold_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            pass_cnt_r <= CNT_ZERO;
            fail_cnt_r <= CNT_ZERO;
            ff_idx_r   <= {CNT_W{1'b1}};
            ff_got_r   <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_n;
            run_cnt_r  <= run_cnt_n;
            wait_cnt_r <= wait_cnt_n;
            num_r      <= num_n;
            stop_r     <= stop_n;
            vec_idx_r  <= vec_idx_n;
            dbg_addr_r <= dbg_addr_n;
            dut_hold_r <= dut_hold_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            pass_r     <= pass_n;
            pass_cnt_r <= pass_cnt_n;
            fail_cnt_r <= fail_cnt_n;
            ff_idx_r   <= ff_idx_n;
            ff_got_r   <= ff_got_n;
        end
    end

    assign vec_idx        = vec_idx_r;
    assign dut_hold       = dut_hold_r;
    assign dbg_addr       = dbg_addr_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign pass_cnt       = pass_cnt_r;
    assign fail_cnt       = fail_cnt_r;
    assign first_fail_idx = ff_idx_r;
    assign first_fail_got = ff_got_r;

endmodule

// File: tb/tb_mem_check_sequencer.sv
// Bench for mem_check_sequencer: three instances (read latency 0, 1, 3)
// share stimulus and a behavioural memory; results are checked against
// table expectations and a sequential reference model.
module tb_mem_check_sequencer;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int NC  = 8;
    localparam int CW  = $clog2(NC + 1);
    localparam int RUN = 5;
    localparam logic [AW-1:0] ARM0_V = 8'h14;
    localparam logic [AW-1:0] ARM1_V = 8'h01;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, stop_on_fail;
    logic [CW-1:0] num_checks;

    logic [CW-1:0] vidx  [3];
    logic [AW-1:0] vaddr [3];
    logic [DW-1:0] vexp  [3];
    logic          hold  [3];
    logic [AW-1:0] daddr [3];
    logic [DW-1:0] ddata [3];
    logic          busy_o[3];
    logic          done_o[3];
    logic          pass_o[3];
    logic [CW-1:0] pc    [3];
    logic [CW-1:0] fc    [3];
    logic [CW-1:0] ffi   [3];
    logic [DW-1:0] ffg   [3];

    logic [DW-1:0] mem      [256];
    logic [AW-1:0] tbl_addr [16];
    logic [DW-1:0] tbl_exp  [16];
    logic [DW-1:0] rd1, p3a, p3b, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural DUT debug port: read latency 0, 1 and 3.
    assign ddata[0] = mem[daddr[0]];
    always @(posedge clk) begin
        rd1 <= mem[daddr[1]];
        p3a <= mem[daddr[2]];
        p3b <= p3a;
        rd3 <= p3b;
    end
    assign ddata[1] = rd1;
    assign ddata[2] = rd3;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            assign vaddr[g] = tbl_addr[vidx[g]];
            assign vexp[g]  = tbl_exp[vidx[g]];
            mem_check_sequencer #(
                .ADDR_W(AW), .DATA_W(DW), .N_CHECKS(NC), .RUN_CYCLES(RUN),
                .READ_LAT((g == 0) ? 0 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .clk(clk), .rst(rst_n), .start(start), .abort(abort),
                .stop_on_fail(stop_on_fail), .num_checks(num_checks),
                .vec_idx(vidx[g]), .vec_addr(vaddr[g]), .vec_exp(vexp[g]),
                .dut_hold(hold[g]), .dbg_addr(daddr[g]), .dbg_data(ddata[g]),
                .busy(busy_o[g]), .done(done_o[g]), .pass(pass_o[g]),
                .pass_cnt(pc[g]), .fail_cnt(fc[g]),
                .first_fail_idx(ffi[g]), .first_fail_got(ffg[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [lat%0d]: got %0h expected %0h", nm, lat_of(g), got, exp);
        end
    endtask

    task automatic reset_check(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk({nm, ".dut_hold"}, g, hold[g], 1);
            chk({nm, ".busy"}, g, busy_o[g], 0);
            chk({nm, ".done"}, g, done_o[g], 0);
            chk({nm, ".pass"}, g, pass_o[g], 0);
            chk({nm, ".dbg_addr"}, g, daddr[g], 0);
            chk({nm, ".vec_idx"}, g, vidx[g], 0);
            chk({nm, ".pass_cnt"}, g, pc[g], 0);
            chk({nm, ".fail_cnt"}, g, fc[g], 0);
            chk({nm, ".first_fail_idx"}, g, ffi[g], 4'hF);
            chk({nm, ".first_fail_got"}, g, ffg[g], 0);
        end
    endtask

    // Distinct addresses, readback 100+i; one optional bad entry expects 7 but reads 9.
    task automatic setup_table(input int bad);
        for (int i = 0; i < 16; i++) begin
            tbl_addr[i] = AW'(16 + i * 3);
            mem[tbl_addr[i]] = DW'(100 + i);
            tbl_exp[i] = DW'(100 + i);
            if (i == bad) begin
                mem[tbl_addr[i]] = 32'd9;
                tbl_exp[i] = 32'd7;
            end
        end
    endtask

    // Reference: walk the vectors in order, counting and stopping per the rules.
    task automatic model(input int n, input bit stp, output int e_pc, output int e_fc,
                         output logic [CW-1:0] e_ffi, output logic [DW-1:0] e_ffg,
                         output logic [CW-1:0] e_vi);
        e_pc = 0; e_fc = 0; e_ffi = 4'hF; e_ffg = 32'd0; e_vi = 4'd0;
        for (int i = 0; i < n; i++) begin
            e_vi = CW'(i);
            if (mem[tbl_addr[i]] == tbl_exp[i]) begin
                e_pc++;
            end else begin
                if (e_fc == 0) begin
                    e_ffi = CW'(i);
                    e_ffg = mem[tbl_addr[i]];
                end
                e_fc++;
                if (stp) break;
            end
        end
    endtask

    task automatic run_and_check(input string nm, input logic [CW-1:0] num_in, input bit stp_in,
                                 input bit pulse_start, input int e_pc, input int e_fc,
                                 input logic [CW-1:0] e_ffi, input logic [DW-1:0] e_ffg,
                                 input logic [CW-1:0] e_vi);
        int edges;
        int budget;
        bit seen [3];
        int done_e [3];
        logic [CW-1:0] prev [3];
        int prev_e [3];
        budget = RUN + 3 + NC * 5 + 10;
        @(negedge clk);
        num_checks = num_in;
        stop_on_fail = stp_in;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        for (int g = 0; g < 3; g++) begin
            chk({nm, ".hold_falls"}, g, hold[g], 0);
            chk({nm, ".busy_on"}, g, busy_o[g], 1);
            seen[g] = 1'b0;
            done_e[g] = -1;
            prev[g] = 4'd0;
            prev_e[g] = RUN + 3;
        end
        while (!(seen[0] && seen[1] && seen[2]) && edges < budget) begin
            start = pulse_start && (edges == 3);
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            for (int g = 0; g < 3; g++) begin
                if (edges == RUN + 1) chk({nm, ".arm0"}, g, daddr[g], ARM0_V);
                if (edges == RUN + 2) chk({nm, ".arm1"}, g, daddr[g], ARM1_V);
                if (!seen[g]) begin
                    if (vidx[g] != prev[g]) begin
                        chk({nm, ".spacing"}, g, edges - prev_e[g], lat_of(g) + 2);
                        prev[g] = vidx[g];
                        prev_e[g] = edges;
                    end
                    if (done_o[g]) begin
                        seen[g] = 1'b1;
                        done_e[g] = edges;
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk({nm, ".finished"}, g, seen[g], 1);
            chk({nm, ".latency"}, g, done_e[g], RUN + 3 + (e_pc + e_fc) * (lat_of(g) + 2));
            chk({nm, ".pass"}, g, pass_o[g], (e_fc == 0));
            chk({nm, ".pass_cnt"}, g, pc[g], e_pc);
            chk({nm, ".fail_cnt"}, g, fc[g], e_fc);
            chk({nm, ".first_fail_idx"}, g, ffi[g], e_ffi);
            chk({nm, ".first_fail_got"}, g, ffg[g], e_ffg);
            chk({nm, ".vec_idx"}, g, vidx[g], e_vi);
            chk({nm, ".busy_off"}, g, busy_o[g], 0);
            chk({nm, ".hold_done"}, g, hold[g], 0);
        end
        // abort outside a busy state must be ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk({nm, ".done_kept"}, g, done_o[g], 1);
            chk({nm, ".pass_kept"}, g, pass_o[g], (e_fc == 0));
        end
    endtask

    typedef struct {
        logic [CW-1:0] num;
        bit            stp;
        int            bad;
        int            e_pc;
        int            e_fc;
        logic [CW-1:0] e_ffi;
        logic [DW-1:0] e_ffg;
        logic [CW-1:0] e_vi;
    } vec_t;

    vec_t tv [7];

    initial begin
        int e_pc, e_fc, raw, n_eff;
        logic [CW-1:0] e_ffi, e_vi;
        logic [DW-1:0] e_ffg;
        bit stp;

        tv[0] = '{4'd4,  1'b0, -1, 4, 0, 4'hF, 32'd0, 4'd3};
        tv[1] = '{4'd5,  1'b0,  2, 4, 1, 4'd2, 32'd9, 4'd4};
        tv[2] = '{4'd5,  1'b1,  2, 2, 1, 4'd2, 32'd9, 4'd2};
        tv[3] = '{4'd0,  1'b0, -1, 0, 0, 4'hF, 32'd0, 4'd0};
        tv[4] = '{4'd12, 1'b0, -1, 8, 0, 4'hF, 32'd0, 4'd7};
        tv[5] = '{4'd9,  1'b0,  3, 7, 1, 4'd3, 32'd9, 4'd7};
        tv[6] = '{4'd8,  1'b1,  7, 7, 1, 4'd7, 32'd9, 4'd7};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stop_on_fail = 1'b0;
        num_checks = 4'd0;
        for (int a = 0; a < 256; a++) mem[a] = 32'd0;
        setup_table(-1);

        repeat (2) @(posedge clk);
        #1;
        reset_check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort.hold", 1, hold[1], 1);
        chk("idle_abort.busy", 1, busy_o[1], 0);

        // Table-driven cases, the first with a start pulse while busy
        for (int t = 0; t < 7; t++) begin
            setup_table(tv[t].bad);
            run_and_check($sformatf("table%0d", t), tv[t].num, tv[t].stp, (t == 0),
                          tv[t].e_pc, tv[t].e_fc, tv[t].e_ffi, tv[t].e_ffg, tv[t].e_vi);
        end

        // Abort during WAIT of vector 1 on the latency-1 instance
        begin
            int edges;
            setup_table(-1);
            @(negedge clk);
            num_checks = 4'd4;
            stop_on_fail = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            edges = 1;
            while (edges < RUN + 7) begin
                @(posedge clk); #1;
                edges++;
            end
            chk("abort.pre_vec_idx", 1, vidx[1], 1);
            abort = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            for (int g = 0; g < 3; g++) begin
                chk("abort.busy", g, busy_o[g], 0);
                chk("abort.hold", g, hold[g], 1);
                chk("abort.done", g, done_o[g], 0);
            end
            chk("abort.pass_cnt_frozen", 1, pc[1], 1);
            chk("abort.fail_cnt_frozen", 1, fc[1], 0);
            chk("abort.vec_idx_frozen", 1, vidx[1], 1);
            @(posedge clk); #1;
            chk("abort.stays_idle", 1, hold[1], 1);
            run_and_check("rerun", 4'd4, 1'b0, 1'b0, 4, 0, 4'hF, 32'd0, 4'd3);
        end

        // Asynchronous reset during RUN, after a run with a failure recorded
        setup_table(2);
        run_and_check("prefail", 4'd5, 1'b0, 1'b0, 4, 1, 4'd2, 32'd9, 4'd4);
        @(negedge clk);
        num_checks = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.hold", 1, hold[1], 1);

        // Randomized runs against the reference model
        for (int r = 0; r < 14; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = $urandom;
            for (int i = 0; i < 16; i++) begin
                tbl_addr[i] = AW'($urandom);
                if ($urandom_range(0, 3) == 0)
                    tbl_exp[i] = mem[tbl_addr[i]] ^ (32'd1 << $urandom_range(0, 31));
                else
                    tbl_exp[i] = mem[tbl_addr[i]];
            end
            raw = $urandom_range(0, 12);
            n_eff = (raw > NC) ? NC : raw;
            stp = 1'($urandom_range(0, 1));
            model(n_eff, stp, e_pc, e_fc, e_ffi, e_ffg, e_vi);
            run_and_check($sformatf("rand%0d", r), CW'(raw), stp, 1'($urandom_range(0, 1)),
                          e_pc, e_fc, e_ffi, e_ffg, e_vi);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
